// File: rtl/demux_1to4_struct.sv
// 1-to-4 demultiplexer with a gate-level routing path, a registered copy, rise pulses
// and optional saturating per-channel activity counters (enable with DEMUX_ACT_CNT_EN).
module demux_1to4_struct #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               data_in,
  input  logic [1:0]         sel,
  output logic [3:0]         out,
  output logic [3:0]         out_q,
  output logic [3:0]         rise,
  output logic [4*CNT_W-1:0] act_cnt
);

  wire       sel_n0;
  wire       sel_n1;
  wire [3:0] out_w;

  // Pure gate network so the routing path stays independent of clk and rst_n.
  not u_not_s0 (sel_n0, sel[0]);
  not u_not_s1 (sel_n1, sel[1]);

  and u_and_o0 (out_w[0], data_in, sel_n1, sel_n0);
  and u_and_o1 (out_w[1], data_in, sel_n1, sel[0]);
  and u_and_o2 (out_w[2], data_in, sel[1], sel_n0);
  and u_and_o3 (out_w[3], data_in, sel[1], sel[0]);

  assign out = out_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 4'b0000;
      rise  <= 4'b0000;
    end else begin
      out_q <= out_w;
      rise  <= out_w & ~out_q;
    end
  end

`ifdef DEMUX_ACT_CNT_EN
  // Each counter only sees its own routed bit, so at most one advances per cycle.
  for (genvar i = 0; i < 4; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (out_w[i] && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign act_cnt[CNT_W*i +: CNT_W] = cnt;
  end
`else
  assign act_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_1to4_struct.sv
// Self-checking bench for demux_1to4_struct: a behavioural model compared every cycle,
// plus directed literal checks for routing, edge detect, saturation and async reset.
module tb_demux_1to4_struct;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk;
  logic               rst_n;
  logic               data_in;
  logic [1:0]         sel;
  logic [3:0]         out;
  logic [3:0]         out_q;
  logic [3:0]         rise;
  logic [4*CNT_W-1:0] act_cnt;

  int errors = 0;
  int checks = 0;

  demux_1to4_struct #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .sel     (sel),
    .out     (out),
    .out_q   (out_q),
    .rise    (rise),
    .act_cnt (act_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: the selected channel gets the data bit, everything else is 0.
  function automatic logic [3:0] model_out(input logic d, input logic [1:0] s);
    logic [3:0] r;
    r = 4'b0000;
    if (d) r[s] = 1'b1;
    return r;
  endfunction

  logic [3:0] exp_q;
  logic [3:0] exp_rise;
  int         exp_cnt [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q    <= 4'b0000;
      exp_rise <= 4'b0000;
      for (int i = 0; i < 4; i++) exp_cnt[i] <= 0;
    end else begin
      exp_q    <= model_out(data_in, sel);
      exp_rise <= model_out(data_in, sel) & ~exp_q;
      if (data_in && exp_cnt[sel] < CNT_MAX) exp_cnt[sel] <= exp_cnt[sel] + 1;
    end
  end

  function automatic logic [4*CNT_W-1:0] model_cnt();
    logic [4*CNT_W-1:0] v;
    v = '0;
`ifdef DEMUX_ACT_CNT_EN
    for (int i = 0; i < 4; i++) v[CNT_W*i +: CNT_W] = exp_cnt[i][CNT_W-1:0];
`endif
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic d, input logic [1:0] s);
    @(negedge clk);
    #1;
    data_in = d;
    sel     = s;
  endtask

  // Model comparison on every falling edge, well away from the active edge.
  always @(negedge clk) begin
    checkOutput("cmp_out",     32'(out),     32'(model_out(data_in, sel)));
    checkOutput("cmp_onehot",  32'($countones(out) <= 1), 32'd1);
    checkOutput("cmp_out_q",   32'(out_q),   32'(exp_q));
    checkOutput("cmp_rise",    32'(rise),    32'(exp_rise));
    checkOutput("cmp_act_cnt", 32'(act_cnt), 32'(model_cnt()));
  end

  logic [3:0]         route_exp [4];
  logic [3:0]         q_exp     [4];
  logic [3:0]         rise_exp  [4];
  int                 sat_exp   [6];
  logic [4*CNT_W-1:0] sat_vec;

  initial begin
    route_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    q_exp     = '{4'b0100, 4'b0100, 4'b0100, 4'b0000};
    rise_exp  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000};
    sat_exp   = '{1, 2, 3, 3, 3, 3};

    rst_n   = 1'b0;
    data_in = 1'b0;
    sel     = 2'b00;
    #1;
    checkOutput("reset_out_q",   32'(out_q),   32'h0);
    checkOutput("reset_rise",    32'(rise),    32'h0);
    checkOutput("reset_act_cnt", 32'(act_cnt), 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Routing with data, then without.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'(i));
      #1 checkOutput("route_data", 32'(out), 32'(route_exp[i]));
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'(i));
      #1 checkOutput("route_nodata", 32'(out), 32'h0);
    end

    // Register and edge detect on channel 2.
    applyStimulus(1'b1, 2'b10);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reg_out_q", 32'(out_q), 32'(q_exp[i]));
      checkOutput("reg_rise",  32'(rise),  32'(rise_exp[i]));
    end
    applyStimulus(1'b0, 2'b10);
    @(posedge clk);
    #1;
    checkOutput("reg_out_q", 32'(out_q), 32'(q_exp[3]));
    checkOutput("reg_rise",  32'(rise),  32'(rise_exp[3]));

    // Reset mid-operation between edges.
    applyStimulus(1'b1, 2'b01);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_q",   32'(out_q),   32'h0);
    checkOutput("midrst_rise",    32'(rise),    32'h0);
    checkOutput("midrst_act_cnt", 32'(act_cnt), 32'h0);
    checkOutput("midrst_out",     32'(out),     32'b0010);
    sel = 2'b11;
    #1 checkOutput("midrst_out_follow", 32'(out), 32'b1000);

    // Resume on channel 1 and drive its counter into saturation.
    applyStimulus(1'b1, 2'b01);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      sat_vec = '0;
`ifdef DEMUX_ACT_CNT_EN
      sat_vec[CNT_W +: CNT_W] = CNT_W'(sat_exp[i]);
`endif
      checkOutput("sat_act_cnt", 32'(act_cnt), 32'(sat_vec));
      if (i == 0) checkOutput("resume_rise", 32'(rise), 32'b0010);
      if (i == 1) checkOutput("resume_rise_end", 32'(rise), 32'b0000);
    end

    // Toggle channel 0 every cycle; rise pulses every other cycle.
    for (int i = 0; i < 6; i++) applyStimulus(1'(i % 2 == 0), 2'b00);
    @(posedge clk);
    #1 checkOutput("toggle_rise", 32'(rise), 32'b0000);

    applyStimulus(1'b0, 2'b00);
    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_1to4_struct.md
# demux_1to4_struct

Gate-level 1-to-4 demultiplexer that routes a single data bit to one of four outputs selected by a 2-bit select. It also provides a registered copy of the outputs, per-output rising-edge pulses and optional per-output activity counters. It sits at the front of a channel-steering path: the combinational outputs feed local logic, and the registered outputs feed downstream clocked logic.

## Interface
Parameters:
- CNT_W, default 8: width of each activity counter (valid range 2..16).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- data_in  input  1  data bit to be routed.
- sel  input  2  output select; 00→out[0], 01→out[1], 10→out[2], 11→out[3].
- out  output  4  combinational demux output.
- out_q  output  4  `out` registered by one clock.
- rise  output  4  one-cycle pulse per bit when out_q goes from 0 to 1.
- act_cnt  output  4*CNT_W  four packed counters; bits [CNT_W*i +: CNT_W] belong to channel i.

## Operation
- Combinational path, built structurally from NOT and AND primitives, with no behavioural `case`:
  - out[0] = data_in & ~sel[1] & ~sel[0]
  - out[1] = data_in & ~sel[1] & sel[0]
  - out[2] = data_in & sel[1] & ~sel[0]
  - out[3] = data_in & sel[1] & sel[0]
- At most one bit of `out` is 1 at any time (one-hot or zero).
- data_in=0 gives out=0000 for every sel value.
- The combinational path does not depend on clk or rst_n; `out` is valid even while reset is asserted.
- out_q <= out on each rising edge of clk.
- rise[i] <= out[i] & ~out_q[i] on each rising edge (registered edge detect).
- act_cnt[i] increments by 1 on each rising edge where out[i]=1.
  - Saturating: holds at 2^CNT_W−1 and does not wrap.
- A sel change on the same edge moves the count to the newly selected channel. No counter ever increments twice in one cycle.

## Timing
- out: zero-cycle combinational path from data_in and sel.
- out_q: latency of 1 clock.
- rise: asserted in the cycle after out[i] rises; width exactly 1 cycle if out[i] stays high. If out[i] toggles every cycle, rise[i] pulses every other cycle.
- act_cnt: the new value is visible 1 clock after a qualifying cycle.
- Reset (rst_n=0) immediately forces out_q=0000, rise=0000 and all act_cnt=0, independent of clk.
- Reset asserted mid-operation discards all state.
- On the first rising edge after rst_n deasserts, registers resume from zero. An out bit already high on that edge produces a rise pulse and a count of 1.
- No handshake; inputs are sampled every cycle.

## Configuration
- Macro DEMUX_ACT_CNT_EN.
- Defined: the four saturating counters are built as described above.
- Undefined: no counter flops are synthesized and act_cnt is tied to all zeros. out, out_q and rise are unaffected.

## Test plan
- Routing with data: data_in=1; sel steps 00, 01, 10, 11 at 10 ns each → out = 0001, 0010, 0100, 1000.
- Routing without data: data_in=0; sel steps 00..11 → out = 0000 for every step, and one-hot-or-zero holds throughout.
- Register and edge detect: data_in=1, sel=10 held for 3 clocks, then data_in=0 →
  - out_q=0100 from the 1st edge onward, then 0000 one clock after data_in falls.
  - rise=0100 for exactly one cycle.
- Saturation (with DEMUX_ACT_CNT_EN, CNT_W=2): data_in=1, sel=01 for 6 clocks → act_cnt[1] reads 1, 2, 3, 3, 3, 3; other counters stay 0.
- Reset mid-operation: counters non-zero, pull rst_n low between edges →
  - out_q, rise and act_cnt read 0 immediately.
  - out still follows data_in and sel.
- Counter compiled out (without DEMUX_ACT_CNT_EN): any stimulus → act_cnt stays all zeros, and all other outputs match the first four scenarios.
